mole_game_core: RTL and testbench

Parametrised game engine for the whack-a-mole design: runs a timed round, pops one mole at a time into one of `N_HOLES` holes using an on-chip LFSR, and scores taps against the active mole with a difficulty-dependent mole lifetime. It replaces the fixed-size game logic in the top level and adds a round timer, penalties, saturating score and status pulses. It drives the display and audio blocks directly and takes debounced, clock-synchronous tap inputs from the input decoder.

---
 rtl/mole_game_core.sv | 179 +++++++++++++++++
 tb/tb_mole_game_core.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_game_core.sv
// Whack-a-mole game engine: timed round, LFSR-placed moles, tap scoring with
// difficulty-dependent mole lifetime, saturating score and hit/miss pulses.
module mole_game_core #(
  parameter int unsigned N_HOLES     = 9,
  parameter int unsigned TICK_DIV    = 10_000_000,
  parameter int unsigned ROUND_TICKS = 300,
  parameter int unsigned SCORE_W     = 8,
  parameter int unsigned TW          = $clog2(ROUND_TICKS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         difficulty,
  input  logic [N_HOLES-1:0] tap,
  output logic [N_HOLES-1:0] holes,
  output logic [SCORE_W-1:0] score,
  output logic [TW-1:0]      time_left,
  output logic               playing,
  output logic               game_over,
  output logic               hit_pulse,
  output logic               miss_pulse
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned IW = $clog2(N_HOLES + 1);
  localparam int unsigned LW = 5;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_UP, S_OVER} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [N_HOLES-1:0] tap_q;
  logic [N_HOLES-1:0] holes_q, holes_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [TW-1:0]      time_q, time_d;
  logic [1:0]         diff_q, diff_d;
  logic [IW-1:0]      prev_q, prev_d;
  logic [LW-1:0]      life_q, life_d;
  logic               playing_q, playing_d;
  logic               over_q, over_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;

  logic               active_c, tick_c, hit_c, miss_c;
  logic [N_HOLES-1:0] tap_rise_c;
  logic [IW-1:0]      idx_raw_c, pick_c;

  function automatic logic [LW-1:0] lifetime(input logic [1:0] d);
    case (d)
      2'd0:    return LW'(20);
      2'd1:    return LW'(12);
      2'd2:    return LW'(8);
      default: return LW'(5);
    endcase
  endfunction

  assign active_c   = (state_q == S_GAP) || (state_q == S_UP);
  assign tick_c     = active_c && (cnt_q == CW'(TICK_DIV - 1));
  assign tap_rise_c = tap & ~tap_q;
  assign hit_c      = (state_q == S_UP) && (|(tap_rise_c & holes_q));
  assign miss_c     = active_c && !hit_c && (|(tap_rise_c & ~holes_q));

  // Next hole: never repeat the previous index.
  assign idx_raw_c = IW'(lfsr_q % 16'(N_HOLES));
  assign pick_c    = (idx_raw_c != prev_q)              ? idx_raw_c :
                     (idx_raw_c == IW'(N_HOLES - 1))    ? '0 : idx_raw_c + IW'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    holes_d  = holes_q;
    score_d  = score_q;
    time_d   = time_q;
    diff_d   = diff_q;
    prev_d   = prev_q;
    life_d   = life_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d = S_GAP;
          score_d = '0;
          time_d  = TW'(ROUND_TICKS);
          cnt_d   = '0;
          diff_d  = difficulty;
          prev_d  = IW'(N_HOLES);
          holes_d = '0;
        end
      end
      S_GAP, S_UP: begin
        cnt_d = tick_c ? '0 : cnt_q + CW'(1);
        if (hit_c) begin
          holes_d = '0;
          score_d = (score_q == SCORE_MAX) ? score_q : score_q + SCORE_W'(1);
          hit_d   = 1'b1;
          state_d = S_GAP;
        end else if (miss_c) begin
          score_d = (score_q == '0) ? score_q : score_q - SCORE_W'(1);
          miss_d  = 1'b1;
        end
        if (tick_c) begin
          if (state_q == S_GAP) begin
            state_d = S_UP;
            holes_d = N_HOLES'(1) << pick_c;
            prev_d  = pick_c;
            life_d  = lifetime(diff_q);
          end else if (!hit_c) begin
            if (life_q <= LW'(1)) begin
              holes_d = '0;
              state_d = S_GAP;
            end else begin
              life_d = life_q - LW'(1);
            end
          end
          // Round end overrides any mole transition; a same-cycle hit still counts.
          time_d = time_q - TW'(1);
          if (time_q <= TW'(1)) begin
            time_d  = '0;
            state_d = S_OVER;
            holes_d = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    playing_d = (state_d == S_GAP) || (state_d == S_UP);
    over_d    = (state_d == S_OVER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      lfsr_q    <= LFSR_SEED;
      tap_q     <= '0;
      holes_q   <= '0;
      score_q   <= '0;
      time_q    <= '0;
      diff_q    <= '0;
      prev_q    <= IW'(N_HOLES);
      life_q    <= '0;
      playing_q <= 1'b0;
      over_q    <= 1'b0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      tap_q     <= tap;
      holes_q   <= holes_d;
      score_q   <= score_d;
      time_q    <= time_d;
      diff_q    <= diff_d;
      prev_q    <= prev_d;
      life_q    <= life_d;
      playing_q <= playing_d;
      over_q    <= over_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
    end
  end

  assign holes      = holes_q;
  assign score      = score_q;
  assign time_left  = time_q;
  assign playing    = playing_q;
  assign game_over  = over_q;
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;

endmodule

// File: tb/tb_mole_game_core.sv
// Scoreboard bench for mole_game_core: tap expectations are queued when driven
// and compared on the following cycle; round timing is checked against edge counts.
module tb_mole_game_core;

  localparam int unsigned N_HOLES     = 4;
  localparam int unsigned TICK_DIV    = 4;
  localparam int unsigned ROUND_TICKS = 20;
  localparam int unsigned SCORE_W     = 4;
  localparam int unsigned TW          = $clog2(ROUND_TICKS + 1);

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [1:0]         difficulty;
  logic [N_HOLES-1:0] tap;
  logic [N_HOLES-1:0] holes;
  logic [SCORE_W-1:0] score;
  logic [TW-1:0]      time_left;
  logic               playing;
  logic               game_over;
  logic               hit_pulse;
  logic               miss_pulse;

  mole_game_core #(
    .N_HOLES    (N_HOLES),
    .TICK_DIV   (TICK_DIV),
    .ROUND_TICKS(ROUND_TICKS),
    .SCORE_W    (SCORE_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .difficulty(difficulty),
    .tap       (tap),
    .holes     (holes),
    .score     (score),
    .time_left (time_left),
    .playing   (playing),
    .game_over (game_over),
    .hit_pulse (hit_pulse),
    .miss_pulse(miss_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int score;
    bit hit;
    bit miss;
    bit chk_holes;
  } exp_t;

  exp_t       sb[$];
  int         n_checks;
  int         n_fail;
  int         edge_n;
  int         exp_score;
  logic [3:0] prev_mole;
  logic [3:0] last_holes;
  bit         have_prev;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: sample after the edge, retire a queued expectation, watch mole placement.
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    edge_n++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq("sb_score", int'(score), e.score);
      check_eq("sb_hit_pulse", int'(hit_pulse), int'(e.hit));
      check_eq("sb_miss_pulse", int'(miss_pulse), int'(e.miss));
      if (e.chk_holes) check_eq("sb_holes_clear", int'(holes), 0);
    end
    if (holes != 0 && last_holes == 0) begin
      if (have_prev) check_eq("no_repeat", int'(holes != prev_mole), 1);
      prev_mole = holes;
      have_prev = 1'b1;
    end
    last_holes = holes;
  endtask

  function automatic logic [3:0] wrong_bit(input logic [3:0] h);
    logic [3:0] r;
    r = 4'b0001;
    for (int i = 3; i >= 0; i--) if (!h[i]) r = 4'b0001 << i;
    return r;
  endfunction

  task automatic tap_drive(input logic [3:0] bits, input bit is_hit);
    exp_t e;
    if (is_hit) exp_score = (exp_score == 15) ? 15 : exp_score + 1;
    else        exp_score = (exp_score == 0) ? 0 : exp_score - 1;
    e.score     = exp_score;
    e.hit       = is_hit;
    e.miss      = !is_hit;
    e.chk_holes = is_hit;
    tap = bits;
    sb.push_back(e);
    cyc();
  endtask

  task automatic expect_quiet();
    exp_t e;
    e.score     = exp_score;
    e.hit       = 1'b0;
    e.miss      = 1'b0;
    e.chk_holes = 1'b0;
    sb.push_back(e);
    cyc();
  endtask

  task automatic wait_mole();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (holes != 0) seen = 1'b1;
      else cyc();
    end
    check_eq("mole_seen", int'(seen), 1);
    check_eq("mole_onehot", int'($onehot(holes)), 1);
  endtask

  task automatic start_round(input logic [1:0] d);
    start      = 1'b1;
    difficulty = d;
    exp_score  = 0;
    have_prev  = 1'b0;
    cyc();
    start  = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    bit over_seen;
    n_checks   = 0;
    n_fail     = 0;
    edge_n     = 0;
    exp_score  = 0;
    prev_mole  = '0;
    last_holes = '0;
    have_prev  = 1'b0;
    rst_n      = 1'b0;
    start      = 1'b0;
    difficulty = 2'd0;
    tap        = '0;

    repeat (3) cyc();
    check_eq("rst_holes", int'(holes), 0);
    check_eq("rst_score", int'(score), 0);
    check_eq("rst_time", int'(time_left), 0);
    check_eq("rst_playing", int'(playing), 0);
    check_eq("rst_game_over", int'(game_over), 0);
    rst_n = 1'b1;
    repeat (2) cyc();
    check_eq("idle_playing", int'(playing), 0);

    // Round 1: difficulty 3, first mole timing and expiry
    start_round(2'd3);
    check_eq("start_playing", int'(playing), 1);
    check_eq("start_time", int'(time_left), 20);
    check_eq("start_holes", int'(holes), 0);
    repeat (3) cyc();
    check_eq("mole_not_early", int'(holes), 0);
    cyc();
    check_eq("first_mole_onehot", int'($onehot(holes)), 1);
    repeat (19) cyc();
    check_eq("mole_alive_last", int'(holes != 0), 1);
    cyc();
    check_eq("mole_expired", int'(holes), 0);
    check_eq("expire_no_penalty", int'(score), 0);
    check_eq("time_after_6_ticks", int'(time_left), 14);

    // Hit, then hold the tap
    wait_mole();
    tap_drive(holes, 1'b1);
    check_eq("hit_back_to_gap", int'(playing), 1);
    repeat (10) expect_quiet();
    tap = '0;
    cyc();

    // Wrong taps down to zero, then a multi-bit tap including the mole
    wait_mole();
    tap_drive(wrong_bit(holes), 1'b0);
    tap = '0;
    cyc();
    tap_drive(wrong_bit(holes), 1'b0);
    tap = '0;
    cyc();
    wait_mole();
    tap_drive(holes | wrong_bit(holes), 1'b1);
    tap = '0;
    cyc();

    // Asynchronous reset while a mole is up
    wait_mole();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_holes", int'(holes), 0);
    check_eq("async_rst_score", int'(score), 0);
    check_eq("async_rst_time", int'(time_left), 0);
    check_eq("async_rst_playing", int'(playing), 0);
    check_eq("async_rst_over", int'(game_over), 0);
    have_prev = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (6) cyc();
    check_eq("post_rst_idle_holes", int'(holes), 0);
    check_eq("post_rst_idle_playing", int'(playing), 0);

    // Round 2: climb to saturation, then let the round run out
    start_round(2'd3);
    for (int k = 0; k < 16; k++) begin
      wait_mole();
      tap_drive(holes, 1'b1);
      tap = '0;
    end
    check_eq("score_saturated", int'(score), 15);
    over_seen = 1'b0;
    for (int i = 0; i < 200 && !over_seen; i++) begin
      cyc();
      if (game_over) over_seen = 1'b1;
    end
    check_eq("round2_over_seen", int'(over_seen), 1);
    check_eq("over_holes", int'(holes), 0);
    check_eq("over_time", int'(time_left), 0);
    check_eq("over_playing", int'(playing), 0);
    repeat (3) cyc();
    check_eq("over_score_held", int'(score), 15);
    check_eq("over_held", int'(game_over), 1);

    // Round 3: restart from OVER, hit on the final tick
    start_round(2'd0);
    check_eq("restart_score", int'(score), 0);
    check_eq("restart_time", int'(time_left), 20);
    check_eq("restart_over_clear", int'(game_over), 0);
    while (edge_n < 79) cyc();
    check_eq("time_before_final", int'(time_left), 1);
    check_eq("mole_up_final", int'(holes != 0), 1);
    tap_drive(holes, 1'b1);
    check_eq("final_over", int'(game_over), 1);
    check_eq("final_time", int'(time_left), 0);
    check_eq("final_playing", int'(playing), 0);
    tap = '0;
    cyc();
    check_eq("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
